// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers each functional unit's completed result in a
// small FIFO and broadcasts up to NUM_CDB of them per cycle, round-robin.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int NUM_CDB    = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_FU-1:0]         fu_valid,
    input  logic [NUM_FU*IDX_W-1:0]   fu_rob_idx,
    input  logic [NUM_FU*DATA_W-1:0]  fu_value,
    output logic [NUM_FU-1:0]         fu_full,
    input  logic                      flush,
    output logic [NUM_CDB-1:0]        cdb_valid,
    output logic [NUM_CDB*IDX_W-1:0]  cdb_index,
    output logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic [NUM_CDB*2-1:0]      cdb_src,
    output logic                      overflow_err
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int LANE_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

    logic [IDX_W-1:0]  mem_idx [NUM_FU][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_val [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr  [NUM_FU];
    logic [PTR_W-1:0]  rd_ptr  [NUM_FU];
    logic [CNT_W-1:0]  count   [NUM_FU];
    logic [RR_W-1:0]   rr_ptr;

    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  grant;
    logic [NUM_CDB-1:0] lane_vld;
    logic [RR_W-1:0]    lane_unit [NUM_CDB];
    logic [IDX_W-1:0]   lane_idx  [NUM_CDB];
    logic [DATA_W-1:0]  lane_val  [NUM_CDB];
    logic [RR_W-1:0]    last_unit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full is decoded from the registered count only; a same-cycle pop does not free a slot.
    always_comb begin
        fu_full = '0;
        push    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_full[i] = (count[i] == CNT_W'(FIFO_DEPTH));
            push[i]    = fu_valid[i] & ~fu_full[i] & ~flush;
        end
    end

    // Scan from rr_ptr and hand the first NUM_CDB non-empty FIFOs to lanes 0, 1, ...
    always_comb begin
        logic [RR_W-1:0]  u;
        logic [LANE_W:0]  n;
        grant     = '0;
        lane_vld  = '0;
        last_unit = rr_ptr;
        u         = '0;
        n         = '0;
        for (int k = 0; k < NUM_CDB; k++) lane_unit[k] = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            u = RR_W'((int'(rr_ptr) + j) % NUM_FU);
            if (count[u] != '0 && n < (LANE_W + 1)'(NUM_CDB)) begin
                grant[u]                   = 1'b1;
                lane_vld[n[LANE_W-1:0]]    = 1'b1;
                lane_unit[n[LANE_W-1:0]]   = u;
                last_unit                  = u;
                n                          = n + 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            lane_idx[k] = mem_idx[lane_unit[k]][rd_ptr[lane_unit[k]]];
            lane_val[k] = mem_val[lane_unit[k]][rd_ptr[lane_unit[k]]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_idx[i][wr_ptr[i]] <= fu_rob_idx[i*IDX_W +: IDX_W];
                mem_val[i][wr_ptr[i]] <= fu_value[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i])  wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (grant[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (push[i] && !grant[i])      count[i] <= count[i] + CNT_W'(1);
                else if (!push[i] && grant[i]) count[i] <= count[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (last_unit == RR_W'(NUM_FU - 1)) ? '0 : last_unit + RR_W'(1);
        end
    end

    // Ungranted lanes drop valid but keep their last payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= '0;
            cdb_index <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            cdb_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                cdb_valid[k] <= lane_vld[k];
                if (lane_vld[k]) begin
                    cdb_index[k*IDX_W +: IDX_W]   <= lane_idx[k];
                    cdb_value[k*DATA_W +: DATA_W] <= lane_val[k];
                    cdb_src[k*2 +: 2]             <= 2'(lane_unit[k]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (|(fu_valid & fu_full)) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes queue their hand-ordered
// broadcasts; a negedge monitor pops and compares every valid lane.
module tb_cdb_arbiter;

    localparam int NF = 4;
    localparam int NC = 2;
    localparam int IW = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NF-1:0]     fu_valid = '0;
    logic [NF*IW-1:0]  fu_rob_idx = '0;
    logic [NF*DW-1:0]  fu_value = '0;
    logic [NF-1:0]     fu_full;
    logic [NC-1:0]     cdb_valid;
    logic [NC*IW-1:0]  cdb_index;
    logic [NC*DW-1:0]  cdb_value;
    logic [NC*2-1:0]   cdb_src;
    logic              overflow_err;

    cdb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fu_valid     (fu_valid),
        .fu_rob_idx   (fu_rob_idx),
        .fu_value     (fu_value),
        .fu_full      (fu_full),
        .flush        (flush),
        .cdb_valid    (cdb_valid),
        .cdb_index    (cdb_index),
        .cdb_value    (cdb_value),
        .cdb_src      (cdb_src),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [21:0] exp_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_bc(int src, int idx, int val);
        exp_q.push_back({2'(src), 4'(idx), 16'(val)});
    endtask

    task automatic set_fu(int i, int idx, int val);
        fu_valid[i]             = 1'b1;
        fu_rob_idx[i*IW +: IW]  = 4'(idx);
        fu_value[i*DW +: DW]    = 16'(val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        chk("sb_drained", 64'(exp_q.size()), 0);
        exp_q.delete();
        fu_valid = '0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_cdb_valid", 64'(cdb_valid), 0);
        chk("rst_fu_full", 64'(fu_full), 0);
        chk("rst_overflow", 64'(overflow_err), 0);
        chk("rst_cdb_payload", 64'({cdb_index, cdb_value, cdb_src}), 0);
    endtask

    // src(2) | idx(4) | value(16) per valid lane, in lane order.
    always @(negedge clk) begin
        logic [21:0] got;
        if (rst_n) begin
            if (cdb_valid[1]) chk("lane_contiguous", 64'(cdb_valid[0]), 1);
            for (int k = 0; k < NC; k++) begin
                if (cdb_valid[k]) begin
                    got = {cdb_src[k*2 +: 2], cdb_index[k*IW +: IW], cdb_value[k*DW +: DW]};
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_bcast lane%0d: got src=%0d idx=%0d val=%h, expected none",
                                 k, got[21:20], got[19:16], got[15:0]);
                    end else begin
                        chk($sformatf("bcast_lane%0d", k), 64'(got), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        // single result, single lane
        do_reset();
        set_fu(0, 3, 16'h00AB);
        expect_bc(0, 3, 16'h00AB);
        tick();
        fu_valid = '0;
        tick();
        chk("t1_valid_e2", 64'(cdb_valid), 2'b01);
        tick();
        chk("t1_valid_e3", 64'(cdb_valid), 2'b00);

        // four units at once, two lanes per cycle
        do_reset();
        set_fu(0, 1, 16'h0011);
        set_fu(1, 2, 16'h0022);
        set_fu(2, 3, 16'h0033);
        set_fu(3, 4, 16'h0044);
        expect_bc(0, 1, 16'h0011);
        expect_bc(1, 2, 16'h0022);
        expect_bc(2, 3, 16'h0033);
        expect_bc(3, 4, 16'h0044);
        tick();
        fu_valid = '0;
        chk("t2_full_e1", 64'(fu_full), 0);
        tick();
        chk("t2_valid_e2", 64'(cdb_valid), 2'b11);
        tick();
        chk("t2_valid_e3", 64'(cdb_valid), 2'b11);
        tick();
        chk("t2_valid_e4", 64'(cdb_valid), 2'b00);
        // rr_ptr back at 0: FU0 must take lane 0 ahead of FU3
        set_fu(3, 5, 16'h0055);
        set_fu(0, 6, 16'h0066);
        expect_bc(0, 6, 16'h0066);
        expect_bc(3, 5, 16'h0055);
        tick();
        fu_valid = '0;
        tick();
        chk("t2_rr_valid", 64'(cdb_valid), 2'b11);
        tick();
        chk("t2_rr_idle", 64'(cdb_valid), 2'b00);

        // FU3 streaming alone
        do_reset();
        for (int n = 0; n < 8; n++) begin
            set_fu(3, n + 8, 16'h3000 + n);
            expect_bc(3, n + 8, 16'h3000 + n);
            tick();
            chk("t3_full3", 64'(fu_full[3]), 0);
            chk("t3_lane1_idle", 64'(cdb_valid[1]), 0);
            chk("t3_lane0", 64'(cdb_valid[0]), (n > 0) ? 1 : 0);
        end
        fu_valid = '0;
        tick();
        chk("t3_tail_valid", 64'(cdb_valid), 2'b01);
        tick();
        chk("t3_drained", 64'(cdb_valid), 2'b00);

        // FU2 backs up behind FU0/FU1, third push overflows
        do_reset();
        set_fu(0, 1, 16'h0A01);
        set_fu(1, 2, 16'h0B01);
        set_fu(2, 3, 16'h0C01);
        expect_bc(0, 1, 16'h0A01);
        expect_bc(1, 2, 16'h0B01);
        expect_bc(2, 3, 16'h0C01);
        expect_bc(0, 4, 16'h0A02);
        expect_bc(1, 5, 16'h0B02);
        expect_bc(2, 6, 16'h0C02);
        tick();
        chk("t4_full_e1", 64'(fu_full), 0);
        set_fu(0, 4, 16'h0A02);
        set_fu(1, 5, 16'h0B02);
        set_fu(2, 6, 16'h0C02);
        tick();
        chk("t4_full_e2", 64'(fu_full), 4'b0100);
        chk("t4_ovf_e2", 64'(overflow_err), 0);
        fu_valid = '0;
        set_fu(2, 15, 16'hDEAD);
        tick();
        fu_valid = '0;
        chk("t4_ovf_e3", 64'(overflow_err), 1);
        chk("t4_full_e3", 64'(fu_full), 0);
        chk("t4_valid_e3", 64'(cdb_valid), 2'b11);
        tick();
        chk("t4_valid_e4", 64'(cdb_valid), 2'b11);
        tick();
        chk("t4_valid_e5", 64'(cdb_valid), 2'b00);
        tick();
        tick();
        chk("t4_ovf_sticky", 64'(overflow_err), 1);

        // flush discards buffered and same-cycle results
        do_reset();
        for (int i = 0; i < NF; i++) set_fu(i, i + 1, 16'h5000 + i);
        expect_bc(0, 1, 16'h5000);
        expect_bc(1, 2, 16'h5001);
        tick();
        for (int i = 0; i < NF; i++) set_fu(i, i + 5, 16'h5100 + i);
        tick();
        chk("t5_full_pre", 64'(fu_full), 4'b1100);
        chk("t5_valid_pre", 64'(cdb_valid), 2'b11);
        fu_valid = '0;
        set_fu(1, 14, 16'h5BAD);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        chk("t5_valid_post", 64'(cdb_valid), 2'b00);
        chk("t5_full_post", 64'(fu_full), 0);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t5_quiet", 64'(cdb_valid), 2'b00);
        end

        // asynchronous reset with three results buffered
        do_reset();
        for (int i = 0; i < NF; i++) set_fu(i, i + 1, 16'h6001 + i);
        expect_bc(0, 1, 16'h6001);
        expect_bc(1, 2, 16'h6002);
        tick();
        fu_valid = '0;
        set_fu(0, 5, 16'h6005);
        tick();
        fu_valid = '0;
        chk("t6_valid_pre", 64'(cdb_valid), 2'b11);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(cdb_valid), 0);
        chk("t6_async_payload", 64'({cdb_index, cdb_value, cdb_src}), 0);
        chk("t6_async_full", 64'(fu_full), 0);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("t6_no_stale", 64'(cdb_valid), 2'b00);
        end
        set_fu(2, 9, 16'h9999);
        expect_bc(2, 9, 16'h9999);
        tick();
        fu_valid = '0;
        tick();
        chk("t6_fresh_valid", 64'(cdb_valid), 2'b01);
        tick();
        chk("t6_fresh_done", 64'(cdb_valid), 2'b00);

        chk("sb_drained_final", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
